// File: rtl/tlb_pkg.sv
// Shared TLB definitions: page sizes, INVTLB op encodings, walker states, lo-bundle layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tlb_pkg;

    localparam logic [5:0] PS_4KB = 6'd12;
    localparam logic [5:0] PS_4MB = 6'd22;

    localparam logic [4:0] INVTLB_ALL0           = 5'd0;
    localparam logic [4:0] INVTLB_ALL1           = 5'd1;
    localparam logic [4:0] INVTLB_G1             = 5'd2;
    localparam logic [4:0] INVTLB_G0             = 5'd3;
    localparam logic [4:0] INVTLB_G0_ASID        = 5'd4;
    localparam logic [4:0] INVTLB_G0_ASID_VA     = 5'd5;
    localparam logic [4:0] INVTLB_G_OR_ASID_VA   = 5'd6;

    typedef enum logic [1:0] {
        WS_IDLE = 2'd0,
        WS_WALK = 2'd1,
        WS_DONE = 2'd2,
        WS_ERR  = 2'd3
    } walk_state_t;

    // lo bundle = {ppn[19:0], plv[1:0], mat[1:0], d, v}
    localparam int LO_W     = 26;
    localparam int LO_V_OFF   = 0;
    localparam int LO_D_OFF   = 1;
    localparam int LO_MAT_OFF = 2;
    localparam int LO_PLV_OFF = 4;
    localparam int LO_PPN_OFF = 6;

endpackage

// File: rtl/tlb_inv_match.sv
// Decides whether one TLB entry is selected by an INVTLB op and its operands.
// Latency: purely combinational.
// Backpressure: none; unsupported ops never hit.
module tlb_inv_match
    import tlb_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [18:0] e_vppn,
    input  logic [5:0]  e_ps,
    input  logic [9:0]  e_asid,
    input  logic        e_g,
    input  logic [9:0]  asid,
    input  logic [18:0] vppn,
    output logic        hit
);

    logic vppn_hit;
    logic asid_hit;

    // A 4MB page ignores the low 10 VPPN bits; every other size compares all bits.
    assign vppn_hit = (e_vppn[18:10] == vppn[18:10]) &&
                      ((e_ps == PS_4MB) || (e_vppn[9:0] == vppn[9:0]));
    assign asid_hit = (e_asid == asid);

    // Per-op selection rule.
    always_comb begin
        hit = 1'b0;
        case (op)
            INVTLB_ALL0, INVTLB_ALL1: hit = 1'b1;
            INVTLB_G1:                hit = e_g;
            INVTLB_G0:                hit = !e_g;
            INVTLB_G0_ASID:           hit = !e_g && asid_hit;
            INVTLB_G0_ASID_VA:        hit = !e_g && asid_hit && vppn_hit;
            INVTLB_G_OR_ASID_VA:      hit = (e_g || asid_hit) && vppn_hit;
            default:                  hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/tlb_invtlb_walker.sv
// Walks every TLB entry once per INVTLB, rewriting matching valid entries with e=0.
// Latency: TLBNUM walk cycles after acceptance, then a 1-cycle done (err 1 cycle after accept for bad ops).
// Backpressure: req_ready only in IDLE; requests while busy are ignored. INVTLB_STATS_EN adds clr_cnt.
module tlb_invtlb_walker
    import tlb_pkg::*;
#(
    parameter int TLBNUM = 16,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_op,
    input  logic [9:0]        req_asid,
    input  logic [18:0]       req_vppn,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [IDXW-1:0]   r_index,
    input  logic              r_e,
    input  logic [18:0]       r_vppn,
    input  logic [5:0]        r_ps,
    input  logic [9:0]        r_asid,
    input  logic              r_g,
    input  logic [LO_W-1:0]   r_lo0,
    input  logic [LO_W-1:0]   r_lo1,
    output logic              we,
    output logic [IDXW-1:0]   w_index,
    output logic              w_e,
    output logic [18:0]       w_vppn,
    output logic [5:0]        w_ps,
    output logic [9:0]        w_asid,
    output logic              w_g,
    output logic [LO_W-1:0]   w_lo0,
    output logic [LO_W-1:0]   w_lo1
`ifdef INVTLB_STATS_EN
    ,
    output logic [IDXW:0]     clr_cnt
`endif
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TLBNUM - 1);

    walk_state_t       state_q, state_d;
    logic [IDXW-1:0]   idx_q;
    logic [4:0]        op_q;
    logic [9:0]        asid_q;
    logic [18:0]       vppn_q;
    logic              accept;
    logic              hit;

    assign accept = req_valid && req_ready;

    tlb_inv_match u_match (
        .op     (op_q),
        .e_vppn (r_vppn),
        .e_ps   (r_ps),
        .e_asid (r_asid),
        .e_g    (r_g),
        .asid   (asid_q),
        .vppn   (vppn_q),
        .hit    (hit)
    );

    // The read port follows the walk index; write data echoes the entry with e forced low.
    assign r_index = idx_q;
    assign w_index = idx_q;
    assign w_e     = 1'b0;
    assign w_vppn  = r_vppn;
    assign w_ps    = r_ps;
    assign w_asid  = r_asid;
    assign w_g     = r_g;
    assign w_lo0   = r_lo0;
    assign w_lo1   = r_lo1;

    // State register; reset aborts any walk in progress.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= WS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control outputs.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        we        = 1'b0;
        case (state_q)
            WS_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    state_d = (req_op <= INVTLB_G_OR_ASID_VA) ? WS_WALK : WS_ERR;
                end
            end
            WS_WALK: begin
                we = r_e && hit;
                if (idx_q == LAST_IDX) begin
                    state_d = WS_DONE;
                end
            end
            WS_DONE: begin
                done    = 1'b1;
                state_d = WS_IDLE;
            end
            WS_ERR: begin
                err     = 1'b1;
                state_d = WS_IDLE;
            end
            default: state_d = WS_IDLE;
        endcase
    end

    // Operand capture on acceptance and index advance during the walk (stops at the last entry).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx_q  <= '0;
            op_q   <= '0;
            asid_q <= '0;
            vppn_q <= '0;
        end else if (accept) begin
            idx_q  <= '0;
            op_q   <= req_op;
            asid_q <= req_asid;
            vppn_q <= req_vppn;
        end else if (state_q == WS_WALK && idx_q != LAST_IDX) begin
            idx_q  <= idx_q + 1'b1;
        end
    end

`ifdef INVTLB_STATS_EN
    // Count of entries cleared by the most recent walk; one extra bit so a full clear fits.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clr_cnt <= '0;
        end else if (accept) begin
            clr_cnt <= '0;
        end else if (we) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_tlb_invtlb_walker.sv
// Self-checking bench: behavioural TLB array plus a rule-level INVTLB model.
// Latency: checks each cycle of every walk against the expected schedule.
// Backpressure: exercises held req_valid across a walk.
module tb_tlb_invtlb_walker;

    localparam int TLBNUM = 16;
    localparam int IDXW   = 4;

    typedef struct packed {
        logic        e;
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic [9:0]  asid;
        logic        g;
        logic [25:0] lo0;
        logic [25:0] lo1;
    } ent_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic req_valid = 1'b0;
    logic [4:0]  req_op = '0;
    logic [9:0]  req_asid = '0;
    logic [18:0] req_vppn = '0;
    logic req_ready, busy, done, err, we, w_e, w_g;
    logic [IDXW-1:0] r_index, w_index;
    logic [18:0] w_vppn;
    logic [5:0]  w_ps;
    logic [9:0]  w_asid;
    logic [25:0] w_lo0, w_lo1;
`ifdef INVTLB_STATS_EN
    logic [IDXW:0] clr_cnt;
`endif

    ent_t tlb [TLBNUM];
    ent_t mdl [TLBNUM];
    ent_t rd;
    logic ld_en = 1'b0;
    logic [IDXW-1:0] ld_idx = '0;
    ent_t ld_dat = '0;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign rd = tlb[r_index];

    // Behavioural TLB storage: DUT write port, or bench loading while the walker is idle.
    always @(posedge clk) begin
        if (we)
            tlb[w_index] <= {w_e, w_vppn, w_ps, w_asid, w_g, w_lo0, w_lo1};
        else if (ld_en)
            tlb[ld_idx] <= ld_dat;
    end

    tlb_invtlb_walker #(.TLBNUM(TLBNUM)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_asid(req_asid), .req_vppn(req_vppn),
        .busy(busy), .done(done), .err(err),
        .r_index(r_index), .r_e(rd.e), .r_vppn(rd.vppn), .r_ps(rd.ps),
        .r_asid(rd.asid), .r_g(rd.g), .r_lo0(rd.lo0), .r_lo1(rd.lo1),
        .we(we), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps),
        .w_asid(w_asid), .w_g(w_g), .w_lo0(w_lo0), .w_lo1(w_lo1)
`ifdef INVTLB_STATS_EN
        , .clr_cnt(clr_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Rule-level reference: would this INVTLB clear entry x?
    function automatic bit ref_hit(int op, ent_t x, logic [9:0] asid, logic [18:0] vppn);
        bit va, as;
        if (!x.e) return 0;
        if (x.ps == 6'd22) va = ((x.vppn >> 10) == (vppn >> 10));
        else               va = (x.vppn == vppn);
        as = (x.asid == asid);
        case (op)
            0, 1: return 1;
            2:    return x.g;
            3:    return !x.g;
            4:    return !x.g && as;
            5:    return !x.g && as && va;
            6:    return (x.g || as) && va;
            default: return 0;
        endcase
    endfunction

    // Copy the model table into the bench TLB; starts and ends on a falling edge.
    task automatic load_tbl();
        for (int i = 0; i < TLBNUM; i++) begin
            ld_en = 1'b1; ld_idx = IDXW'(i); ld_dat = mdl[i];
            @(negedge clk);
        end
        ld_en = 1'b0;
    endtask

    function automatic ent_t rand_ent(logic [9:0] asid, logic [18:0] vppn);
        ent_t x;
        x.e    = ($urandom_range(0, 3) != 0);
        x.g    = $urandom_range(0, 1);
        x.asid = $urandom_range(0, 1) ? asid : 10'($urandom);
        x.vppn = $urandom_range(0, 1) ? vppn ^ 19'($urandom_range(0, 3) << $urandom_range(0, 12)) : 19'($urandom);
        x.ps   = $urandom_range(0, 1) ? 6'd22 : 6'd12;
        x.lo0  = 26'($urandom);
        x.lo1  = 26'($urandom);
        return x;
    endfunction

    // One request from acceptance to ready-again; call and return on a falling edge.
    task automatic run_req(input int op, input logic [9:0] asid, input logic [18:0] vppn, input bit hold);
        bit   exp_hit [TLBNUM];
        ent_t snap [TLBNUM];
        int   nhit = 0;
        int   bad = 0;
        for (int i = 0; i < TLBNUM; i++) begin
            snap[i]    = mdl[i];
            exp_hit[i] = ref_hit(op, mdl[i], asid, vppn);
            if (exp_hit[i]) nhit++;
        end
        req_valid = 1'b1; req_op = 5'(op); req_asid = asid; req_vppn = vppn;
        chk("c0_ready", req_ready, 1);
        chk("c0_busy", busy, 0);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        if (op > 6) begin
            chk("err_pulse", err, 1);
            chk("err_we", we, 0);
            chk("err_done", done, 0);
            chk("err_ready", req_ready, 0);
            @(negedge clk);
            chk("err_ready2", req_ready, 1);
            chk("err_clr", err, 0);
            chk("err_done2", done, 0);
            return;
        end
        for (int i = 0; i < TLBNUM; i++) begin
            chk("walk_busy", busy, 1);
            chk("walk_ready", req_ready, 0);
            chk("walk_rindex", r_index, i);
            chk("walk_done", done, 0);
            chk("walk_we", we, exp_hit[i]);
            if (exp_hit[i]) begin
                chk("w_index", w_index, i);
                chk("w_e", w_e, 0);
                chk("w_fields", {w_vppn, w_ps, w_asid, w_g, w_lo0, w_lo1},
                    {snap[i].vppn, snap[i].ps, snap[i].asid, snap[i].g, snap[i].lo0, snap[i].lo1});
                mdl[i].e = 1'b0;
            end
            @(negedge clk);
        end
        chk("done_pulse", done, 1);
        chk("done_we", we, 0);
        chk("done_err", err, 0);
        chk("done_ready", req_ready, 0);
        @(negedge clk);
        chk("end_ready", req_ready, 1);
        chk("end_done", done, 0);
        for (int i = 0; i < TLBNUM; i++) if (tlb[i] !== mdl[i]) bad++;
        chk("table", bad, 0);
`ifdef INVTLB_STATS_EN
        chk("clr_cnt", clr_cnt, nhit);
`endif
    endtask

    initial begin
        // Reset state.
        #12;
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_we", we, 0);
        chk("rst_rindex", r_index, 0);
`ifdef INVTLB_STATS_EN
        chk("rst_cnt", clr_cnt, 0);
`endif
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Op 0 over a fully valid table.
        for (int i = 0; i < TLBNUM; i++) begin
            mdl[i] = rand_ent(10'h5, 19'h12345);
            mdl[i].e = 1'b1;
        end
        load_tbl();
        run_req(0, 10'h5, 19'h12345, 0);

        // Op 5: only the non-global 4KB entry at 3 matches; global twin at 7 survives.
        for (int i = 0; i < TLBNUM; i++) begin
            mdl[i] = rand_ent(10'h3ff, 19'(i));
            mdl[i].e = 1'b1; mdl[i].g = 1'b0; mdl[i].vppn = 19'(i); mdl[i].ps = 6'd12;
        end
        mdl[3].asid = 10'h5; mdl[3].vppn = 19'h12345;
        mdl[7].asid = 10'h5; mdl[7].vppn = 19'h12345; mdl[7].g = 1'b1;
        load_tbl();
        run_req(5, 10'h5, 19'h12345, 0);

        // Op 6 against a global 4MB entry, then the same entry as 4KB.
        for (int i = 0; i < TLBNUM; i++) begin
            mdl[i] = rand_ent(10'h100, 19'(i));
            mdl[i].e = 1'b1; mdl[i].g = 1'b0; mdl[i].asid = 10'h100; mdl[i].vppn = 19'(i);
        end
        mdl[2].vppn = 19'h12000; mdl[2].ps = 6'd22; mdl[2].g = 1'b1;
        load_tbl();
        run_req(6, 10'h5, 19'h121FF, 0);
        mdl[2].e = 1'b1; mdl[2].ps = 6'd12;
        load_tbl();
        run_req(6, 10'h5, 19'h121FF, 0);

        // Unsupported op.
        run_req(9, 10'h5, 19'h12345, 0);

        // Reset in the fifth walk cycle.
        for (int i = 0; i < TLBNUM; i++) begin
            mdl[i] = rand_ent(10'h5, 19'h0);
            mdl[i].e = 1'b1;
        end
        load_tbl();
        req_valid = 1'b1; req_op = 5'd0;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_we_before", we, 1);
        resetn = 1'b0;
        #1;
        chk("mid_we", we, 0);
        chk("mid_busy", busy, 0);
        chk("mid_ready", req_ready, 1);
        chk("mid_done", done, 0);
`ifdef INVTLB_STATS_EN
        chk("mid_cnt", clr_cnt, 0);
`endif
        begin
            int bad = 0;
            for (int i = 0; i < TLBNUM; i++) if (tlb[i].e !== (i >= 4)) bad++;
            chk("mid_table", bad, 0);
        end
        @(negedge clk);
        chk("mid_done2", done, 0);
        resetn = 1'b1;
        for (int i = 0; i < TLBNUM; i++) mdl[i] = tlb[i];
        @(negedge clk);

        // Back-to-back with req_valid held; second request lands at cycle 18.
        for (int i = 0; i < TLBNUM; i++) begin
            mdl[i] = rand_ent(10'h5, 19'h0);
            mdl[i].e = 1'b1;
            mdl[i].g = (i % 3 == 0) && (i < 18);
        end
        load_tbl();
        run_req(3, 10'h5, 19'h0, 1);
        run_req(2, 10'h5, 19'h0, 0);

        // Op 3 with exactly six non-global entries.
        for (int i = 0; i < TLBNUM; i++) begin
            mdl[i] = rand_ent(10'h5, 19'h0);
            mdl[i].e = 1'b1;
            mdl[i].g = (i >= 6);
        end
        load_tbl();
        run_req(3, 10'h5, 19'h0, 0);

        // Randomized tables and ops.
        for (int t = 0; t < 25; t++) begin
            logic [9:0]  a;
            logic [18:0] v;
            int op;
            a = 10'($urandom_range(0, 3));
            v = 19'($urandom);
            op = $urandom_range(0, 7);
            if (op == 7) op = $urandom_range(7, 31);
            for (int i = 0; i < TLBNUM; i++) mdl[i] = rand_ent(a, v);
            load_tbl();
            run_req(op, a, v, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tlb_invtlb_walker.md
Name: tlb_invtlb_walker

Overview:
- Sequencer that executes one LoongArch INVTLB instruction against the TLB array.
- Accepts the op, ASID and VPPN from the EX/MEM stage and walks every entry, one per cycle, through the TLB's combinational read port.
- For each entry that matches, it issues a write with e=0 on the TLB write port; all other fields are written back unchanged.
- Sits directly upstream of the TLB write port. The parent muxes this block's write port against TLBWR/TLBFILL.

Parameters:
- TLBNUM, 16, number of TLB entries; must be a power of two, 2..64.
- IDXW, $clog2(TLBNUM), entry index width (derived; do not override).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  INVTLB request valid.
- req_ready  out  1  high only in IDLE.
- req_op  in  5  invtlb op code.
- req_asid  in  10  ASID operand (rj[9:0]).
- req_vppn  in  19  VA operand bits [31:13] (rk).
- busy  out  1  state != IDLE; the pipeline stalls on it.
- done  out  1  1-cycle pulse when the walk completes.
- err  out  1  1-cycle pulse for an unsupported op (raises INE).
- r_index  out  IDXW  TLB read index.
- r_e  in  1  entry enable.
- r_vppn  in  19  entry VPPN.
- r_ps  in  6  entry page size (12 or 22).
- r_asid  in  10  entry ASID.
- r_g  in  1  entry global bit.
- r_lo0  in  26  {ppn0,plv0,mat0,d0,v0}.
- r_lo1  in  26  {ppn1,plv1,mat1,d1,v1}.
- we  out  1  TLB write enable.
- w_index  out  IDXW  write index.
- w_e  out  1  always 0.
- w_vppn  out  19  copy of r_vppn.
- w_ps  out  6  copy of r_ps.
- w_asid  out  10  copy of r_asid.
- w_g  out  1  copy of r_g.
- w_lo0  out  26  copy of r_lo0.
- w_lo1  out  26  copy of r_lo1.

Behaviour:
- Clock and reset: single clock clk; resetn is asynchronous and active-low.
- Reset values: state=IDLE, idx=0, op/asid/vppn regs=0. Outputs at reset: req_ready=1, busy=0, done=0, err=0, we=0, r_index=0.
- FSM states: IDLE, WALK, DONE, ERR.
- IDLE: a request is accepted when req_valid && req_ready. On acceptance, latch op/asid/vppn and clear idx to 0.
  - Ops 0..6 go to WALK.
  - Ops 7..31 go to ERR.
- WALK: r_index=idx. The match result is combinational on the r_* inputs the same cycle. we = r_e && match(op), with w_index=idx.
  - idx increments every cycle.
  - At idx==TLBNUM-1 go to DONE; there is no wrap, so the last entry is processed exactly once.
- DONE: done=1 for one cycle, then go to IDLE.
- ERR: err=1 for one cycle, then go to IDLE. No write is ever issued.
- Latency:
  - Valid op: accepted at cycle 0, entries walked in cycles 1..TLBNUM, done in cycle TLBNUM+1, req_ready high again from cycle TLBNUM+2.
  - Invalid op: accepted at cycle 0, err in cycle 1, req_ready high from cycle 2.
- VA match: vppn_hit = r_vppn[18:10]==vppn[18:10] && (r_ps==22 || r_vppn[9:0]==vppn[9:0]). Any ps other than 22 is treated as 4KB.
- ASID match: asid_hit = r_asid==asid.
- Per-op match:
  - op 0, 1: all entries.
  - op 2: g=1.
  - op 3: g=0.
  - op 4: g=0 && asid_hit.
  - op 5: g=0 && asid_hit && vppn_hit.
  - op 6: (g=1 || asid_hit) && vppn_hit.
- Entries with r_e=0 are never written.
- req_valid while busy is ignored and not queued; the upstream stage holds it.
- Reset mid-walk: immediate return to IDLE and we drops asynchronously. Entries already cleared stay cleared, and no done pulse is issued.
- The parent gives this block's write port priority while busy. TLBWR/TLBFILL cannot issue while busy because the pipeline is stalled.

Optional Feature:
- Macro: INVTLB_STATS_EN.
- When defined:
  - Adds output clr_cnt [IDXW:0]: the number of entries written in the last walk.
  - It clears to 0 on request acceptance and increments on each we, so it can reach TLBNUM without overflow.
  - It holds its value after DONE and is reset to 0.
- When undefined: no port and no counter. All other behaviour is identical.

Decomposition:
- Shared package tlb_pkg:
  - Localparams PS_4KB=6'd12 and PS_4MB=6'd22.
  - INVTLB op encodings INVTLB_ALL0..INVTLB_G_OR_ASID_VA (0..6).
  - Walker state encoding.
  - LO_W=26 and the field offsets within a lo bundle.
- Sub-module: tlb_inv_match, combinational. Inputs: op, entry fields, operands. Output: hit. It is reusable by a future parallel-clear implementation.

Test Plan:
- Op 0 with all 16 entries e=1 -> we high on cycles 1..16 with w_index 0..15 and w_e=0; done at cycle 17; req_ready=1 at cycle 18.
- Op 5, asid=0x05, vppn=0x12345 (a 4KB entry at index 3 matches, a g=1 entry at index 7 has the same VA) -> exactly one write, at index 3; all other fields echo r_*.
- Op 6 against a 4MB entry (vppn 0x12000, ps=22) with vppn=0x121FF, asid mismatch, g=1 -> hit; the same case with ps=12 -> no write.
- Op 9 -> err pulse at cycle 1, no we in any cycle, done never asserted, req_ready back at cycle 2.
- resetn low at WALK cycle 5 -> we=0 immediately, state IDLE, no done; entries 0..3 stay cleared. With INVTLB_STATS_EN: clr_cnt=0.
- Back-to-back: req_valid held high through a walk -> the second request is accepted only at cycle 18. With INVTLB_STATS_EN: op 3 over 16 entries with 6 having g=0 gives clr_cnt=6.
